// File: rtl/ovl_mem_pkg.sv
// Shared types for the overlay SDRAM scheduler: FSM states, word type and
// the byte stride of one overlay word.
package ovl_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWaitWr,
    StRd,
    StWaitRd
  } ovl_state_e;

  localparam int unsigned WORD_BYTES = 2;

  // {A,B,G,R}, 4 bits each
  typedef logic [15:0] ovl_word_t;

endpackage

// File: rtl/ovl_mem_sched_if.sv
// Overlay SDRAM port: request/response bus between the scheduler (master)
// and the sdram controller (slave).
interface ovl_mem_sched_if #(
  parameter int unsigned AW = 25
) ();

  logic                   mem_busy;
  logic                   mem_ack;
  ovl_mem_pkg::ovl_word_t mem_dout;
  logic [AW-1:0]          mem_addr;
  logic [7:0]             mem_din;
  logic                   mem_we;
  logic                   mem_rd;

  modport master (
    input  mem_busy,
    input  mem_ack,
    input  mem_dout,
    output mem_addr,
    output mem_din,
    output mem_we,
    output mem_rd
  );

  modport slave (
    output mem_busy,
    output mem_ack,
    output mem_dout,
    input  mem_addr,
    input  mem_din,
    input  mem_we,
    input  mem_rd
  );

endinterface

// File: rtl/ovl_sync_fifo.sv
// Prefetch FIFO for overlay words: first-word fall-through head, synchronous
// flush, push and pop allowed in the same cycle.
module ovl_sync_fifo
  import ovl_mem_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  ovl_word_t                wdata_i,
  input  logic                     pop_i,
  output ovl_word_t                rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0]   FullCnt = Depth[PtrW:0];
  localparam logic [PtrW:0]   CntOne  = 1;
  localparam logic [PtrW-1:0] PtrOne  = 1;

  ovl_word_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign do_push = push_i && (count_q != FullCnt);
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ovl_mem_sched.sv
// Overlay SDRAM scheduler: arbitrates download byte writes against the pixel
// read-ahead stream. Optional OVL_UNDERRUN_CNT_EN adds underrun statistics.
module ovl_mem_sched
  import ovl_mem_pkg::*;
#(
  parameter int unsigned AW         = 25,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ovl_en,
  input  logic             dl_active,
  input  logic             dl_wr,
  input  logic [AW-1:0]    dl_addr,
  input  logic [7:0]       dl_data,
  output logic             dl_wait,
  input  logic             vs,
  input  logic             pix_ce,
  output ovl_word_t        pix_data,
  output logic             pix_valid,
  output logic             underrun,
`ifdef OVL_UNDERRUN_CNT_EN
  output logic [15:0]      underrun_cnt,
  output logic [15:0]      underrun_last,
`endif
  ovl_mem_sched_if.master  mem
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] FifoCap  = CntW'(FIFO_DEPTH);
  localparam logic [AW-1:0]   AddrStep = AW'(WORD_BYTES);

  ovl_state_e      state_q, state_d;

  logic            wr_full_q, wr_full_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            stale_q, stale_d;
  logic            vs_q, dl_active_q;
  ovl_word_t       pix_data_q, pix_data_d;
  logic            pix_valid_q, pix_valid_d;
  logic            underrun_q, underrun_d;

  logic            vs_rise, flush, rd_ok;
  logic            fifo_push, fifo_pop, fifo_empty;
  ovl_word_t       fifo_rdata;
  logic [CntW-1:0] fifo_count;

  assign vs_rise = vs && !vs_q;
  // End of a download restarts the frame so pre-download data is never shown.
  assign flush   = vs_rise || (!dl_active && dl_active_q);
  // Only consulted in StIdle, where nothing is outstanding.
  assign rd_ok   = ovl_en && !dl_active && (fifo_count < FifoCap);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!mem.mem_busy) begin
          if (wr_full_q)  state_d = StWr;
          else if (rd_ok) state_d = StRd;
        end
      end
      StWr:     state_d = StWaitWr;
      StWaitWr: if (mem.mem_ack) state_d = StIdle;
      StRd:     state_d = StWaitRd;
      StWaitRd: if (mem.mem_ack) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    mem.mem_we   = 1'b0;
    mem.mem_rd   = 1'b0;
    mem.mem_addr = '0;
    mem.mem_din  = '0;
    unique case (state_q)
      StWr: begin
        mem.mem_we   = 1'b1;
        mem.mem_addr = wr_addr_q;
        mem.mem_din  = wr_data_q;
      end
      StRd: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = rd_addr_q;
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    wr_full_d = wr_full_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (state_q == StWaitWr && mem.mem_ack) begin
      wr_full_d = 1'b0;
    end else if (dl_wr && !wr_full_q) begin
      wr_full_d = 1'b1;
      wr_addr_d = dl_addr;
      wr_data_d = dl_data;
    end

    rd_addr_d = rd_addr_q;
    if (flush)                 rd_addr_d = '0;
    else if (state_q == StRd)  rd_addr_d = rd_addr_q + AddrStep;

    // A read in flight across a frame restart belongs to the old frame.
    stale_d = stale_q;
    if (state_q == StWaitRd && mem.mem_ack)                  stale_d = 1'b0;
    else if (flush && (state_q == StRd || state_q == StWaitRd)) stale_d = 1'b1;

    fifo_push = (state_q == StWaitRd) && mem.mem_ack && !stale_q && !flush;

    fifo_pop    = 1'b0;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    underrun_d  = 1'b0;
    if (pix_ce) begin
      if (fifo_empty) begin
        pix_data_d  = '0;
        pix_valid_d = 1'b0;
        underrun_d  = 1'b1;
      end else if (!ovl_en || dl_active) begin
        pix_data_d  = '0;
        pix_valid_d = 1'b0;
      end else begin
        fifo_pop    = 1'b1;
        pix_data_d  = fifo_rdata;
        pix_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_full_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      stale_q     <= 1'b0;
      vs_q        <= 1'b0;
      dl_active_q <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      wr_full_q   <= wr_full_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      stale_q     <= stale_d;
      vs_q        <= vs;
      dl_active_q <= dl_active;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  ovl_sync_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_sys),
    .reset_i (reset),
    .flush_i (flush),
    .push_i  (fifo_push),
    .wdata_i (mem.mem_dout),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign dl_wait   = wr_full_q;
  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign underrun  = underrun_q;

`ifdef OVL_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;
  logic [15:0] ulast_q, ulast_d;

  always_comb begin
    ucnt_d  = ucnt_q;
    ulast_d = ulast_q;
    if (vs_rise) begin
      ulast_d = ucnt_q;
      ucnt_d  = '0;
    end else if (underrun_q && ucnt_q != 16'hFFFF) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ucnt_q  <= '0;
      ulast_q <= '0;
    end else begin
      ucnt_q  <= ucnt_d;
      ulast_q <= ulast_d;
    end
  end

  assign underrun_cnt  = ucnt_q;
  assign underrun_last = ulast_q;
`endif

endmodule

// File: tb/tb_ovl_mem_sched.sv
// Scoreboard bench for ovl_mem_sched: stimulus queues expected SDRAM requests
// and pixel words; negedge monitors pop and compare as the DUT presents them.
module tb_ovl_mem_sched;
  import ovl_mem_pkg::*;

  localparam int unsigned AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset, ovl_en, dl_active, dl_wr, vs, pix_ce;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          dl_wait, pix_valid, underrun;
  ovl_word_t     pix_data;

  always #5 clk_sys = ~clk_sys;

  ovl_mem_sched_if #(.AW(AW)) mem_bus ();

  ovl_mem_sched #(
    .AW         (AW),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ovl_en    (ovl_en),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .dl_wait   (dl_wait),
    .vs        (vs),
    .pix_ce    (pix_ce),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .underrun  (underrun),
    .mem       (mem_bus)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
  } req_t;

  typedef struct packed {
    logic      valid;
    ovl_word_t data;
    logic      urun;
  } pix_t;

  req_t exp_req[$];
  pix_t exp_pix[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SDRAM model: ack after lat cycles, read data = 0xB000 + byte address.
  int lat = 2;
  int pend = 0;
  always @(negedge clk_sys) begin
    mem_bus.mem_ack = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) mem_bus.mem_ack = 1'b1;
    end
    if (mem_bus.mem_we || mem_bus.mem_rd) begin
      pend = lat;
      mem_bus.mem_dout = 16'hB000 + 16'(mem_bus.mem_addr);
    end
  end

  // Request monitor
  always @(negedge clk_sys) begin
    req_t e;
    if (mem_bus.mem_we || mem_bus.mem_rd) begin
      if (exp_req.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got we=%0b rd=%0b addr %h, expected no request",
                 mem_bus.mem_we, mem_bus.mem_rd, mem_bus.mem_addr);
      end else begin
        e = exp_req.pop_front();
        chk("req_we", 32'(mem_bus.mem_we), 32'(e.we));
        chk("req_rd", 32'(mem_bus.mem_rd), 32'(!e.we));
        chk("req_addr", 32'(mem_bus.mem_addr), 32'(e.addr));
        if (e.we) chk("req_din", 32'(mem_bus.mem_din), 32'(e.din));
      end
    end
  end

  // Pixel monitor: outputs are due one cycle after each pix_ce.
  logic pce_prev = 1'b0;
  always @(negedge clk_sys) begin
    pix_t p;
    if (pce_prev) begin
      if (exp_pix.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pix: got valid=%0b data %h, expected none", pix_valid, pix_data);
      end else begin
        p = exp_pix.pop_front();
        chk("pix_valid", 32'(pix_valid), 32'(p.valid));
        chk("pix_data", 32'(pix_data), 32'(p.data));
        chk("underrun", 32'(underrun), 32'(p.urun));
      end
    end
    pce_prev = pix_ce;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic exp_rd(input logic [AW-1:0] a);
    req_t r;
    r.we = 1'b0; r.addr = a; r.din = 8'h00;
    exp_req.push_back(r);
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [7:0] d);
    req_t r;
    r.we = 1'b1; r.addr = a; r.din = d;
    exp_req.push_back(r);
  endtask

  task automatic pop_expect(input logic v, input ovl_word_t d, input logic u);
    pix_t p;
    p.valid = v; p.data = d; p.urun = u;
    exp_pix.push_back(p);
    pix_ce = 1'b1;
    tick();
    pix_ce = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_req.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_req.size()), 32'd0);
  endtask

  task automatic wait_rd(input string name);
    int n = 0;
    while (!mem_bus.mem_rd && n < 100) begin
      tick();
      n++;
    end
    chk(name, 32'(mem_bus.mem_rd), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; ovl_en = 1'b0; dl_active = 1'b0; dl_wr = 1'b0;
    dl_addr = '0; dl_data = '0; vs = 1'b0; pix_ce = 1'b0;
    mem_bus.mem_busy = 1'b0;
    tick(3);

    chk("rst_mem_we", 32'(mem_bus.mem_we), 32'd0);
    chk("rst_mem_rd", 32'(mem_bus.mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
    chk("rst_dl_wait", 32'(dl_wait), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    tick(2);

    // Download: four bytes, ack latency 3, one illegal strobe while full.
    dl_active = 1'b1;
    lat = 3;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      exp_wr(AW'(i), 8'hA1 + 8'(i));
      dl_addr = AW'(i); dl_data = 8'hA1 + 8'(i); dl_wr = 1'b1;
      tick();
      dl_wr = 1'b0;
      chk("dl_wait_set", 32'(dl_wait), 32'd1);
      if (i == 1) begin
        dl_addr = AW'(32'h55); dl_data = 8'hEE; dl_wr = 1'b1;
        tick();
        dl_wr = 1'b0;
        chk("dl_wait_hold", 32'(dl_wait), 32'd1);
      end
      n = 0;
      while (dl_wait && n < 50) begin
        tick();
        n++;
      end
      chk("dl_wait_clear", 32'(dl_wait), 32'd0);
    end
    dl_active = 1'b0;
    drain("dl_reqs", 50);
    tick(4);

    // Prefetch fill: eight reads, then stall on a full FIFO.
    lat = 2;
    for (int i = 0; i < 8; i++) exp_rd(AW'(2 * i));
    ovl_en = 1'b1;
    drain("fill_reqs", 200);
    tick(12);

    // vs while read 0x10 is outstanding: its data is dropped, restart at 0.
    exp_rd(AW'(32'h10));
    for (int i = 0; i < 8; i++) exp_rd(AW'(2 * i));
    pop_expect(1'b1, 16'hB000, 1'b0);
    wait_rd("rd_0x10_issued");
    tick();
    vs = 1'b1;
    tick(3);
    vs = 1'b0;
    drain("refill_reqs", 200);
    tick(12);

    // Back-to-back pops in order; each frees a slot for the next read.
    exp_rd(AW'(32'h10)); exp_rd(AW'(32'h12)); exp_rd(AW'(32'h14));
    pop_expect(1'b1, 16'hB000, 1'b0);
    pop_expect(1'b1, 16'hB002, 1'b0);
    pop_expect(1'b1, 16'hB004, 1'b0);
    drain("topup_reqs", 100);
    tick(12);

    // Drain with the SDRAM busy: eight words then two underruns.
    mem_bus.mem_busy = 1'b1;
    lat = 6;
    tick(2);
    for (int i = 0; i < 8; i++) pop_expect(1'b1, 16'hB006 + 16'(2 * i), 1'b0);
    pop_expect(1'b0, 16'h0000, 1'b1);
    pop_expect(1'b0, 16'h0000, 1'b1);
    tick();
    chk("underrun_low", 32'(underrun), 32'd0);

    // Pending write and eligible read together: write goes first.
    exp_wr(AW'(32'h1234), 8'h5C);
    for (int i = 0; i < 8; i++) exp_rd(AW'(32'h16 + 2 * i));
    dl_addr = AW'(32'h1234); dl_data = 8'h5C; dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
    mem_bus.mem_busy = 1'b0;
    drain("wr_then_rd_reqs", 300);
    tick(12);

    // Reset during a read; its late ack must be ignored.
    exp_rd(AW'(32'h26));
    pop_expect(1'b1, 16'hB016, 1'b0);
    wait_rd("rd_0x26_issued");
    tick();
    reset = 1'b1;
    ovl_en = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("post_rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("post_rst_pix_data", 32'(pix_data), 32'd0);
    chk("post_rst_dl_wait", 32'(dl_wait), 32'd0);
    chk("post_rst_mem_rd", 32'(mem_bus.mem_rd), 32'd0);
    tick(8);
    lat = 2;
    for (int i = 0; i < 8; i++) exp_rd(AW'(2 * i));
    exp_rd(AW'(32'h10));
    ovl_en = 1'b1;
    n = 0;
    while (exp_req.size() > 1 && n < 200) begin
      tick();
      n++;
    end
    tick(8);
    pop_expect(1'b1, 16'hB000, 1'b0);
    drain("post_rst_reqs", 100);
    tick(12);

    chk("pix_queue_empty", 32'(exp_pix.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
